// File: rtl/ram_copy_engine.sv
// ram_copy_engine: drives one byte-addressed RAM port to copy a block of
// 32-bit words from src to dst, or to fill a block at dst with a pattern.
// Read data returns one cycle after the read request, so a copy alternates
// READ and WRITE (2 cycles/word) while a fill writes every cycle.
//
// Request semantics: start_i is a level request with no ready. It is
// accepted on any rising clk edge where the engine is in IDLE; while
// busy_o=1 or done_o=1 it is ignored. Completion (normal or error) is
// signalled by a single-cycle done_o pulse. An aborted transfer returns to
// IDLE without a done_o pulse.
module ram_copy_engine #(
    parameter  int MEM_WIDTH = 65536,
    parameter  int LEN_W     = 16,
    localparam int ADDR_W    = $clog2(MEM_WIDTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [31:0]       pattern_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i
);

    // Bounds sums are wide enough that base + 4*len can never wrap.
    localparam int SUM_W = ADDR_W + LEN_W + 2;
    localparam logic [SUM_W-1:0] MEM_LIMIT = SUM_W'(MEM_WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  remaining;
    logic              mode_q;      // 0 = copy, 1 = fill
    logic [31:0]       pattern_q;

    logic [SUM_W-1:0]  src_end;
    logic [SUM_W-1:0]  dst_end;
    logic              cfg_err;

    // Parameter check on the latched request; only consulted in CHECK, where
    // the pointers still hold the start addresses and remaining holds len.
    always_comb begin
        src_end = SUM_W'(src_ptr) + SUM_W'({remaining, 2'b00});
        dst_end = SUM_W'(dst_ptr) + SUM_W'({remaining, 2'b00});
        cfg_err = (dst_ptr[1:0] != 2'b00) || (dst_end > MEM_LIMIT);
        if (!mode_q) begin
            cfg_err = cfg_err || (src_ptr[1:0] != 2'b00) || (src_end > MEM_LIMIT);
        end
    end

    // Write data: copy forwards the word read last cycle, fill sends the pattern.
    assign mem_data_o = (state == WRITE) ? (mode_q ? pattern_q : mem_data_i) : 32'h0;

    // Sequencer: every output is registered for the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            remaining  <= '0;
            mode_q     <= 1'b0;
            pattern_q  <= 32'h0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            mem_en_o   <= 1'b0;
            mem_we_o   <= 4'h0;
            mem_addr_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        src_ptr   <= src_addr_i;
                        dst_ptr   <= dst_addr_i;
                        remaining <= len_i;
                        mode_q    <= mode_i;
                        pattern_q <= pattern_i;
                        error_o   <= 1'b0;
                        busy_o    <= 1'b1;
                        state     <= CHECK;
                    end
                end

                CHECK: begin
                    if (abort_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (cfg_err) begin
                        error_o <= 1'b1;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state   <= DONE;
                    end else if (remaining == '0) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else if (!mode_q) begin
                        mem_en_o   <= 1'b1;
                        mem_we_o   <= 4'h0;
                        mem_addr_o <= src_ptr;
                        state      <= READ;
                    end else begin
                        mem_en_o   <= 1'b1;
                        mem_we_o   <= 4'hF;
                        mem_addr_o <= dst_ptr;
                        state      <= WRITE;
                    end
                end

                READ: begin
                    if (abort_i) begin
                        mem_en_o <= 1'b0;
                        mem_we_o <= 4'h0;
                        busy_o   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        mem_en_o   <= 1'b1;
                        mem_we_o   <= 4'hF;
                        mem_addr_o <= dst_ptr;
                        state      <= WRITE;
                    end
                end

                WRITE: begin
                    src_ptr   <= src_ptr + ADDR_W'(4);
                    dst_ptr   <= dst_ptr + ADDR_W'(4);
                    remaining <= remaining - LEN_W'(1);
                    if (abort_i) begin
                        mem_en_o <= 1'b0;
                        mem_we_o <= 4'h0;
                        busy_o   <= 1'b0;
                        state    <= IDLE;
                    end else if (remaining == LEN_W'(1)) begin
                        mem_en_o <= 1'b0;
                        mem_we_o <= 4'h0;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        state    <= DONE;
                    end else if (!mode_q) begin
                        mem_en_o   <= 1'b1;
                        mem_we_o   <= 4'h0;
                        mem_addr_o <= src_ptr + ADDR_W'(4);
                        state      <= READ;
                    end else begin
                        mem_en_o   <= 1'b1;
                        mem_we_o   <= 4'hF;
                        mem_addr_o <= dst_ptr + ADDR_W'(4);
                        state      <= WRITE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    mem_en_o <= 1'b0;
                    mem_we_o <= 4'h0;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a byte-enable RAM model whose read
// data is registered. Every write the engine issues is matched in order
// against an expected queue of {address, data}.
module tb_ram_copy_engine;

    logic        clk;
    logic        reset_n;
    logic        start_i;
    logic        mode_i;
    logic        abort_i;
    logic [15:0] src_addr_i;
    logic [15:0] dst_addr_i;
    logic [15:0] len_i;
    logic [31:0] pattern_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    int n_cmp;
    int n_err;
    int en_cnt;
    int done_total;
    int unexp_cnt;
    int bad_we_cnt;

    logic [63:0] exp_q[$];

    // RAM model and back-door preload port
    logic [31:0] ram [0:16383];
    logic        tb_wr_en;
    logic [13:0] tb_wr_idx;
    logic [31:0] tb_wr_data;

    ram_copy_engine #(.MEM_WIDTH(65536), .LEN_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .abort_i    (abort_i),
        .src_addr_i (src_addr_i),
        .dst_addr_i (dst_addr_i),
        .len_i      (len_i),
        .pattern_i  (pattern_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o),
        .mem_en_o   (mem_en_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: registered read, byte-enable write, read-before-write
    always @(posedge clk) begin
        if (tb_wr_en) begin
            ram[tb_wr_idx] <= tb_wr_data;
        end else if (mem_en_o) begin
            mem_data_i <= ram[mem_addr_o[15:2]];
            for (int b = 0; b < 4; b++) begin
                if (mem_we_o[b]) ram[mem_addr_o[15:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_en_o) en_cnt++;
            if (done_o) done_total++;
            if (mem_we_o != 4'h0 && !mem_en_o) bad_we_cnt++;
            if (mem_en_o && mem_we_o != 4'h0) begin
                if (exp_q.size() == 0) begin
                    unexp_cnt++;
                end else begin
                    check("write_addr_data", {16'h0, mem_addr_o, mem_data_o}, exp_q.pop_front());
                    check("write_we", {60'h0, mem_we_o}, 64'hF);
                end
            end
        end
    end

    // driver tasks
    task automatic ram_load(input logic [15:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        tb_wr_en   = 1'b1;
        tb_wr_idx  = addr[15:2];
        tb_wr_data = data;
        @(posedge clk);
        #1;
        tb_wr_en = 1'b0;
    endtask

    task automatic expect_write(input logic [15:0] addr, input logic [31:0] data);
        exp_q.push_back({16'h0, addr, data});
    endtask

    // caller is just after a rising edge; start is seen on the next edge
    task automatic launch(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic [31:0] p);
        mode_i     = m;
        src_addr_i = s;
        dst_addr_i = d;
        len_i      = l;
        pattern_i  = p;
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int bc, output int dc);
        bit saw;
        saw = 0;
        bc  = 0;
        dc  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy_o) bc++;
            if (done_o) begin
                dc++;
                saw = 1;
            end
            if (saw && !done_o) break;
        end
        if (!saw) check({tag, "_timeout"}, 64'(dc), 64'd1);
    endtask

    task automatic do_xfer(input string tag, input logic m, input logic [15:0] s,
                           input logic [15:0] d, input logic [15:0] l, input logic [31:0] p,
                           output int bc, output int dc);
        @(posedge clk);
        #1;
        launch(m, s, d, l, p);
        wait_done(tag, bc, dc);
    endtask

    int bc, dc, base_en, base_done, wcnt;

    initial begin
        n_cmp = 0; n_err = 0; en_cnt = 0; done_total = 0; unexp_cnt = 0; bad_we_cnt = 0;
        tb_wr_en = 1'b0; tb_wr_idx = '0; tb_wr_data = '0;
        start_i = 1'b0; mode_i = 1'b0; abort_i = 1'b0;
        src_addr_i = '0; dst_addr_i = '0; len_i = '0; pattern_i = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        check("rst_en", 64'(mem_en_o), 64'd0);
        check("rst_we", 64'(mem_we_o), 64'd0);
        check("rst_addr", 64'(mem_addr_o), 64'd0);
        check("rst_data", 64'(mem_data_o), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // copy 4 words 0x100 -> 0x200
        ram_load(16'h0100, 32'h11111111);
        ram_load(16'h0104, 32'h22222222);
        ram_load(16'h0108, 32'h33333333);
        ram_load(16'h010C, 32'h44444444);
        expect_write(16'h0200, 32'h11111111);
        expect_write(16'h0204, 32'h22222222);
        expect_write(16'h0208, 32'h33333333);
        expect_write(16'h020C, 32'h44444444);
        base_en = en_cnt;
        do_xfer("copy", 1'b0, 16'h0100, 16'h0200, 16'd4, 32'h0, bc, dc);
        check("copy_busy_cycles", 64'(bc), 64'd9);
        check("copy_done_pulses", 64'(dc), 64'd1);
        check("copy_en_cycles", 64'(en_cnt - base_en), 64'd8);
        check("copy_error", 64'(error_o), 64'd0);
        check("copy_ram_200", 64'(ram[16'h0200 >> 2]), 64'h11111111);
        check("copy_ram_20c", 64'(ram[16'h020C >> 2]), 64'h44444444);

        // fill 3 words at 0x40
        ram_load(16'h003C, 32'h12345678);
        ram_load(16'h004C, 32'h9ABCDEF0);
        expect_write(16'h0040, 32'hDEADBEEF);
        expect_write(16'h0044, 32'hDEADBEEF);
        expect_write(16'h0048, 32'hDEADBEEF);
        base_en = en_cnt;
        do_xfer("fill", 1'b1, 16'h0000, 16'h0040, 16'd3, 32'hDEADBEEF, bc, dc);
        check("fill_busy_cycles", 64'(bc), 64'd4);
        check("fill_done_pulses", 64'(dc), 64'd1);
        check("fill_en_cycles", 64'(en_cnt - base_en), 64'd3);
        check("fill_ram_44", 64'(ram[16'h0044 >> 2]), 64'hDEADBEEF);
        check("fill_ram_3c_untouched", 64'(ram[16'h003C >> 2]), 64'h12345678);
        check("fill_ram_4c_untouched", 64'(ram[16'h004C >> 2]), 64'h9ABCDEF0);

        // misaligned destination
        base_en = en_cnt;
        do_xfer("err_align", 1'b1, 16'h0000, 16'h0202, 16'd1, 32'h0, bc, dc);
        check("err_align_error", 64'(error_o), 64'd1);
        check("err_align_done", 64'(dc), 64'd1);
        check("err_align_busy", 64'(bc), 64'd1);
        check("err_align_no_en", 64'(en_cnt - base_en), 64'd0);

        // out of bounds by one word
        base_en = en_cnt;
        do_xfer("err_bound", 1'b1, 16'h0000, 16'hFFFC, 16'd2, 32'h0, bc, dc);
        check("err_bound_error", 64'(error_o), 64'd1);
        check("err_bound_no_en", 64'(en_cnt - base_en), 64'd0);

        // last word exactly fits; also clears the sticky error
        expect_write(16'hFFFC, 32'hA5A5A5A5);
        do_xfer("edge_fit", 1'b1, 16'h0000, 16'hFFFC, 16'd1, 32'hA5A5A5A5, bc, dc);
        check("edge_fit_error_cleared", 64'(error_o), 64'd0);
        check("edge_fit_ram", 64'(ram[16'hFFFC >> 2]), 64'hA5A5A5A5);

        // len=0 with start held high through DONE
        base_en = en_cnt;
        @(posedge clk);
        #1;
        mode_i = 1'b0; src_addr_i = 16'h0100; dst_addr_i = 16'h0300; len_i = 16'd0;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("len0_check_busy", 64'(busy_o), 64'd1);
        @(negedge clk);
        check("len0_done", 64'({busy_o, done_o, error_o}), 64'b010);
        @(negedge clk);
        check("len0_start_ignored_in_done", 64'({busy_o, done_o}), 64'b00);
        @(negedge clk);
        check("len0_restart_from_idle", 64'(busy_o), 64'd1);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("len0_no_access", 64'(en_cnt - base_en), 64'd0);

        // abort in the 3rd WRITE of an 8-word copy
        for (int i = 0; i < 8; i++) ram_load(16'h0300 + 16'(4 * i), 32'hC0DE0000 + 32'(i));
        ram_load(16'h040C, 32'hCAFEF00D);
        expect_write(16'h0400, 32'hC0DE0000);
        expect_write(16'h0404, 32'hC0DE0001);
        expect_write(16'h0408, 32'hC0DE0002);
        base_en   = en_cnt;
        base_done = done_total;
        @(posedge clk);
        #1;
        launch(1'b0, 16'h0300, 16'h0400, 16'd8, 32'h0);
        wcnt = 0;
        for (int i = 0; i < 50 && wcnt < 3; i++) begin
            @(negedge clk);
            if (mem_en_o && mem_we_o == 4'hF) wcnt++;
        end
        check("abort_reached_3rd_write", 64'(wcnt), 64'd3);
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        check("abort_idle_busy", 64'(busy_o), 64'd0);
        check("abort_idle_en", 64'(mem_en_o), 64'd0);
        launch(1'b1, 16'h0000, 16'h0500, 16'd1, 32'h5A5A0001);
        @(negedge clk);
        check("abort_done_never", 64'(done_total - base_done), 64'd0);
        check("abort_en_cycles", 64'(en_cnt - base_en), 64'd6);
        check("abort_restart_busy", 64'(busy_o), 64'd1);
        expect_write(16'h0500, 32'h5A5A0001);
        wait_done("abort_restart", bc, dc);
        check("abort_restart_done", 64'(dc), 64'd1);
        check("abort_no_4th_write", 64'(ram[16'h040C >> 2]), 64'hCAFEF00D);
        check("abort_restart_ram", 64'(ram[16'h0500 >> 2]), 64'h5A5A0001);

        // asynchronous reset during a READ
        @(posedge clk);
        #1;
        launch(1'b0, 16'h0100, 16'h0600, 16'd4, 32'h0);
        wcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_en_o && mem_we_o == 4'h0) begin
                wcnt = 1;
                break;
            end
        end
        check("rstmid_reached_read", 64'(wcnt), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_en_async", 64'(mem_en_o), 64'd0);
        check("rstmid_busy_async", 64'(busy_o), 64'd0);
        check("rstmid_we_async", 64'(mem_we_o), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rstmid_idle", 64'({busy_o, done_o, mem_en_o}), 64'b000);
        expect_write(16'h0600, 32'h11111111);
        expect_write(16'h0604, 32'h22222222);
        expect_write(16'h0608, 32'h33333333);
        expect_write(16'h060C, 32'h44444444);
        do_xfer("rstmid_copy", 1'b0, 16'h0100, 16'h0600, 16'd4, 32'h0, bc, dc);
        check("rstmid_copy_busy", 64'(bc), 64'd9);
        check("rstmid_copy_ram_60c", 64'(ram[16'h060C >> 2]), 64'h44444444);

        repeat (2) @(negedge clk);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        check("unexpected_writes", 64'(unexp_cnt), 64'd0);
        check("we_without_en", 64'(bad_we_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_copy_engine.md
Name: ram_copy_engine

Overview:
- Memory-initiator block that drives one port of the dual-port simulation/system RAM to copy or fill blocks of 32-bit words without core involvement.
- Sits beside the RS5 core and drives the RAM port the core does not use.
- Talks to the RAM's byte-addressed port: enable, 4-bit byte write-enable, address, write data. Read data is registered inside the RAM and returns one cycle after the read request.

Parameters:
- MEM_WIDTH, 65536, RAM size in bytes; address width is ADDR_W = $clog2(MEM_WIDTH).
- LEN_W, 16, width of the word-count input.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start_i  input  1  request a transfer; sampled only in IDLE.
- mode_i  input  1  0 = copy src->dst, 1 = fill dst with pattern_i.
- abort_i  input  1  cancel an in-progress transfer.
- src_addr_i  input  ADDR_W  source byte address (copy mode).
- dst_addr_i  input  ADDR_W  destination byte address.
- len_i  input  LEN_W  number of 32-bit words.
- pattern_i  input  32  fill word (fill mode).
- busy_o  output  1  transfer in progress.
- done_o  output  1  one-cycle completion pulse.
- error_o  output  1  sticky parameter error; cleared by the next accepted start.
- mem_en_o  output  1  RAM port enable.
- mem_we_o  output  4  RAM byte write-enable.
- mem_addr_o  output  ADDR_W  RAM byte address.
- mem_data_o  output  32  RAM write data.
- mem_data_i  input  32  RAM read data, valid the cycle after a read request.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - busy_o, done_o, error_o, mem_en_o = 0.
  - mem_we_o, mem_addr_o, mem_data_o = 0.
  - Internal counters and pointers = 0.
  - Reset mid-transfer drops mem_en_o immediately. The partial transfer is not resumed.
- States: IDLE, CHECK, READ, WRITE, DONE.
- IDLE:
  - On start_i=1: latch src, dst, len, mode and pattern; clear error_o; go to CHECK.
  - start_i while not in IDLE is ignored.
- CHECK (1 cycle, no memory access, busy_o=1):
  - Error if src[1:0]!=0 (copy mode only), dst[1:0]!=0, dst+4*len>MEM_WIDTH, or (copy mode) src+4*len>MEM_WIDTH.
  - Bounds sums are computed at ADDR_W+LEN_W+2 bits, so there is no wrap.
  - On error: error_o=1, go to DONE, no memory access.
  - If len=0: go to DONE, no access, no error.
  - Otherwise: copy mode goes to READ, fill mode goes to WRITE.
- READ (copy mode):
  - mem_en_o=1, mem_we_o=0, mem_addr_o=src pointer.
  - Next state is WRITE.
- WRITE:
  - mem_en_o=1, mem_we_o=4'hF, mem_addr_o=dst pointer.
  - mem_data_o = mem_data_i in copy mode (the word read in the previous cycle); pattern in fill mode.
  - At the clock edge: src and dst pointers += 4, remaining -= 1.
  - If remaining was 1: go to DONE. Otherwise copy mode goes to READ and fill mode stays in WRITE.
- Throughput: copy takes 2 cycles per word; fill takes 1 cycle per word.
- DONE:
  - done_o=1 and busy_o=0 for exactly one cycle, then IDLE.
  - start_i during DONE is ignored.
- busy_o=1 in CHECK, READ and WRITE only.
- mem_we_o is never nonzero unless mem_en_o=1.
- In IDLE, CHECK and DONE: mem_en_o=0, mem_we_o=0.
- Addresses increase strictly. Overlapping copies with dst>src propagate forward; there is no overlap protection.
- abort_i=1 in CHECK, READ or WRITE:
  - The memory access of the current cycle completes; the next state is IDLE.
  - No done_o pulse; error_o unchanged.
  - abort_i in IDLE or DONE has no effect.
  - abort_i has priority over the normal WRITE->DONE transition.
- Outputs are driven from registered state and pointers. mem_data_o in copy mode is a combinational pass-through of mem_data_i.

Test Plan:
- Copy: RAM[0x100..0x10C]=11111111,22222222,33333333,44444444; start copy src=0x100 dst=0x200 len=4 -> 8 alternating read/write cycles; RAM[0x200..0x20C] matches the source; done_o pulses once 1 cycle after the last write; busy_o high for 9 cycles (CHECK plus 8).
- Fill: mode=1, dst=0x40, len=3, pattern=DEADBEEF -> 3 consecutive write cycles at 0x40, 0x44, 0x48 with we=F; done_o pulse; RAM[0x3C] and RAM[0x4C] untouched.
- Errors:
  - dst=0x202 len=1 -> error_o=1 and done_o pulse; mem_en_o never asserted.
  - dst=0xFFFC len=2 with MEM_WIDTH=65536 -> error_o=1.
  - dst=0xFFFC len=1 -> succeeds.
  - A following valid start clears error_o.
- len=0 -> busy_o 1 cycle, done_o pulse, error_o=0, zero memory accesses; start_i held high in DONE is ignored, and a new transfer begins only from IDLE.
- Abort: copy len=8, abort_i asserted in the 3rd WRITE -> that write lands; no further en; no done_o; state IDLE next cycle; a new start is accepted immediately.
- Reset mid-copy: reset_n low during READ -> mem_en_o, busy_o, mem_we_o drop to 0 without waiting for clk; after release the block is IDLE and runs a fresh copy correctly.
